// File: rtl/theia_wb_mem_responder_if.sv
// rtl/theia_wb_mem_responder_if.sv - Wishbone bus bundle between THEIACORE master and memory responder
// Purpose: groups the Wishbone slave-side signals; names follow the responder's view.
// Ports (signals):
//   ADR_I  word address        DAT_I  write data        DAT_O  read data
//   WE_I   1=write             STB_I  strobe            CYC_I  bus cycle
//   TGA_I  bank tag            ACK_O  transfer acknowledge
interface theia_wb_mem_responder_if #(
  parameter int DW = 32
);
  logic [DW-1:0] ADR_I;
  logic [DW-1:0] DAT_I;
  logic [DW-1:0] DAT_O;
  logic          WE_I;
  logic          STB_I;
  logic          CYC_I;
  logic [1:0]    TGA_I;
  logic          ACK_O;

  modport master (
    output ADR_I, DAT_I, WE_I, STB_I, CYC_I, TGA_I,
    input  DAT_O, ACK_O
  );

  modport slave (
    input  ADR_I, DAT_I, WE_I, STB_I, CYC_I, TGA_I,
    output DAT_O, ACK_O
  );
endinterface

// File: rtl/theia_wb_mem_responder.sv
// rtl/theia_wb_mem_responder.sv - Wishbone slave memory model with wait states and host backdoor
// Purpose: two word-addressed banks (geometry, texture) served over Wishbone with
//   programmable wait states and a single-cycle ACK; a host backdoor preloads data.
// Ports:
//   CLK_I        clock
//   RST_I        synchronous active-low reset
//   wb           Wishbone slave bundle (ADR/DAT/WE/STB/CYC/TGA in, DAT_O/ACK_O out)
//   iHostWE      backdoor write strobe
//   iHostBank    backdoor bank (0 geo, 1 tex)
//   iHostAddr    backdoor word address
//   iHostData    backdoor write data
//   oWriteCount  committed Wishbone writes, saturating
//   oBusy        FSM not idle
module theia_wb_mem_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_STATES = 2,
  parameter int DW          = 32
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  theia_wb_mem_responder_if.slave wb,
  input  logic                 iHostWE,
  input  logic                 iHostBank,
  input  logic [ADDR_BITS-1:0] iHostAddr,
  input  logic [DW-1:0]        iHostData,
  output logic [15:0]          oWriteCount,
  output logic                 oBusy
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state;
  logic [3:0]           wait_cnt;
  logic [ADDR_BITS-1:0] lat_adr;
  logic [DW-1:0]        lat_dat;
  logic                 lat_we;
  logic [1:0]           lat_tga;

  logic [DW-1:0] mem [0:1][0:DEPTH-1];

  logic                 req;
  logic                 last_wait;
  logic                 enter_ack;
  logic [ADDR_BITS-1:0] c_adr;
  logic [DW-1:0]        c_dat;
  logic                 c_we;
  logic [1:0]           c_tga;
  logic                 wb_wr;
  logic                 unused_adr_hi;

  // Upper address bits alias onto the bank; they are intentionally ignored.
  assign unused_adr_hi = ^wb.ADR_I[DW-1:ADDR_BITS];

  assign req       = wb.CYC_I & wb.STB_I;
  assign last_wait = (wait_cnt == 4'(WAIT_STATES - 1));

  // With zero wait states the commit happens straight from IDLE, so the live bus
  // values are used; otherwise the values latched at capture time.
  always_comb begin
    enter_ack = 1'b0;
    c_adr     = lat_adr;
    c_dat     = lat_dat;
    c_we      = lat_we;
    c_tga     = lat_tga;
    if (state == S_IDLE) begin
      c_adr     = wb.ADR_I[ADDR_BITS-1:0];
      c_dat     = wb.DAT_I;
      c_we      = wb.WE_I;
      c_tga     = wb.TGA_I;
      enter_ack = RST_I && req && (WAIT_STATES == 0);
    end else if (state == S_WAIT) begin
      enter_ack = RST_I && req && last_wait;
    end
  end

  // Reserved tags (bit 1 set) are acknowledged but never touch memory.
  assign wb_wr = enter_ack && c_we && !c_tga[1];
  assign oBusy = (state != S_IDLE);

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      wb.ACK_O    <= 1'b0;
      wb.DAT_O    <= '0;
      oWriteCount <= '0;
      lat_adr     <= '0;
      lat_dat     <= '0;
      lat_we      <= 1'b0;
      lat_tga     <= '0;
    end else begin
      wb.ACK_O <= enter_ack;
      if (enter_ack) begin
        if (!c_we) begin
          wb.DAT_O <= c_tga[1] ? '0 : mem[c_tga[0]][c_adr];
        end else if (!c_tga[1] && oWriteCount != 16'hFFFF) begin
          oWriteCount <= oWriteCount + 16'd1;
        end
      end
      case (state)
        S_IDLE: begin
          if (req) begin
            lat_adr  <= wb.ADR_I[ADDR_BITS-1:0];
            lat_dat  <= wb.DAT_I;
            lat_we   <= wb.WE_I;
            lat_tga  <= wb.TGA_I;
            wait_cnt <= '0;
            state    <= (WAIT_STATES == 0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!req) begin
            state <= S_IDLE;
          end else if (last_wait) begin
            state <= S_ACK;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_ACK:   state <= S_DONE;
        // DONE swallows the cycle in which a registered master is still showing STB.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory is never reset. Wishbone write is ordered last so it wins a same-edge
  // collision with the host backdoor.
  always_ff @(posedge CLK_I) begin
    if (iHostWE) begin
      mem[iHostBank][iHostAddr] <= iHostData;
    end
    if (wb_wr) begin
      mem[c_tga[0]][c_adr] <= c_dat;
    end
  end

endmodule
